// File: rtl/btn_pkg.sv
// Shared types and constants for the front-panel button conditioner.
// Defaults target a 100 MHz board clock.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_HELD,
        BTN_LONG
    } btn_state_t;

    localparam int unsigned CLK_HZ                = 100_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1_000_000;   // 10 ms
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 15_000_000;  // 150 ms
    localparam int unsigned DEF_REPEAT_CYCLES     = 25_000_000;  // 250 ms

    localparam int unsigned BTN_MODE       = 0;
    localparam int unsigned BTN_EDIT_SHIFT = 1;
    localparam int unsigned BTN_INC        = 2;
    localparam int unsigned BTN_START_STOP = 3;
    localparam int unsigned BTN_RESET      = 4;

    // One width shared by all per-channel counters, sized for the largest timing value.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce filter, press/long/repeat FSM.
// Every output is a flop; nothing from the raw pin reaches an output combinationally.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_short_release_pulse,
    output logic o_long_pulse,
    output logic o_repeat_pulse
);

    localparam int unsigned CNT_W =
        cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  =
        CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    btn_state_t       r_state;
    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_level    <= 1'b0;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_state    <= BTN_IDLE;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;

            if (r_sync2 == r_level) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_level   <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + CNT_ONE;
            end

            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;

            // Falling level is tested first so a release always beats long/repeat.
            case (r_state)
                BTN_IDLE: begin
                    if (r_level) begin
                        r_state    <= BTN_HELD;
                        r_press    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                BTN_HELD: begin
                    if (!r_level) begin
                        r_state   <= BTN_IDLE;
                        r_release <= 1'b1;
                        r_short   <= 1'b1;
                    end else if (r_hold_cnt == LONG_LAST) begin
                        r_state   <= BTN_LONG;
                        r_long    <= 1'b1;
                        r_rep_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_ONE;
                    end
                end
                BTN_LONG: begin
                    if (!r_level) begin
                        r_state   <= BTN_IDLE;
                        r_release <= 1'b1;
                    end else if (REPEAT_EN) begin
                        if (r_rep_cnt == REP_LAST) begin
                            r_repeat  <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + CNT_ONE;
                        end
                    end
                end
                default: r_state <= BTN_IDLE;
            endcase
        end
    end

    assign o_btn_level           = r_level;
    assign o_press_pulse         = r_press;
    assign o_release_pulse       = r_release;
    assign o_short_release_pulse = r_short;
    assign o_long_pulse          = r_long;
    assign o_repeat_pulse        = r_repeat;

endmodule

// File: rtl/button_event_conditioner.sv
// Front-panel button conditioner: one independent btn_channel per button,
// plus an any-button-down summary flag.
module button_event_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN             = 5,
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_press_pulse,
    output logic [N_BTN-1:0] o_release_pulse,
    output logic [N_BTN-1:0] o_short_release_pulse,
    output logic [N_BTN-1:0] o_long_pulse,
    output logic [N_BTN-1:0] o_repeat_pulse,
    output logic             o_any_active
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES)
        ) u_ch (
            .clk                  (clk),
            .reset                (reset),
            .i_btn_raw            (i_btn_raw[g]),
            .o_btn_level          (o_btn_level[g]),
            .o_press_pulse        (o_press_pulse[g]),
            .o_release_pulse      (o_release_pulse[g]),
            .o_short_release_pulse(o_short_release_pulse[g]),
            .o_long_pulse         (o_long_pulse[g]),
            .o_repeat_pulse       (o_repeat_pulse[g])
        );
    end

    // OR of flopped levels only, so still no path from the raw pins.
    assign o_any_active = |o_btn_level;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench: two instances (repeat enabled / disabled) driven with the same
// raw buttons, compared every cycle against a hand-computed event schedule.
module tb_button_event_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] raw;

    logic [1:0] a_level, a_press, a_rel, a_short, a_long, a_rep;
    logic       a_any;
    logic [1:0] b_level, b_press, b_rel, b_short, b_long, b_rep;
    logic       b_any;

    always #5 clk = ~clk;

    button_event_conditioner #(
        .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .REPEAT_CYCLES(8)
    ) dut_a (
        .clk(clk), .reset(reset), .i_btn_raw(raw),
        .o_btn_level(a_level), .o_press_pulse(a_press), .o_release_pulse(a_rel),
        .o_short_release_pulse(a_short), .o_long_pulse(a_long), .o_repeat_pulse(a_rep),
        .o_any_active(a_any)
    );

    button_event_conditioner #(
        .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .REPEAT_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .i_btn_raw(raw),
        .o_btn_level(b_level), .o_press_pulse(b_press), .o_release_pulse(b_rel),
        .o_short_release_pulse(b_short), .o_long_pulse(b_long), .o_repeat_pulse(b_rep),
        .o_any_active(b_any)
    );

    // kind: 0 press, 1 release, 2 short_release, 3 long, 4 repeat
    typedef struct {
        int len;
        int r0a_on, r0a_off, r0b_on, r0b_off;
        int r1_on, r1_off;
        int rst_cyc;
    } scen_t;
    typedef struct { int sc; int cyc; int ch; int kind; } ev_t;
    typedef struct { int sc; int cyc; logic [1:0] lvl; logic any; } lvl_t;

    localparam int NSC = 7;
    scen_t scen[NSC];
    ev_t   evs[$];
    lvl_t  lvls[$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic set_scen(input int s, input int len, input int r0a_on, input int r0a_off,
                            input int r0b_on, input int r0b_off, input int r1_on,
                            input int r1_off, input int rst_cyc);
        scen[s].len = len;
        scen[s].r0a_on = r0a_on;  scen[s].r0a_off = r0a_off;
        scen[s].r0b_on = r0b_on;  scen[s].r0b_off = r0b_off;
        scen[s].r1_on  = r1_on;   scen[s].r1_off  = r1_off;
        scen[s].rst_cyc = rst_cyc;
    endtask

    task automatic add_ev(input int sc, input int cyc, input int ch, input int kind);
        ev_t e;
        e.sc = sc; e.cyc = cyc; e.ch = ch; e.kind = kind;
        evs.push_back(e);
    endtask

    task automatic add_lvl(input int sc, input int cyc, input logic [1:0] lvl, input logic any);
        lvl_t l;
        l.sc = sc; l.cyc = cyc; l.lvl = lvl; l.any = any;
        lvls.push_back(l);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int expected(input int sc, input int cyc, input int ch, input int kind,
                                    input bit no_repeat);
        if (no_repeat && kind == 4) return 0;
        foreach (evs[i])
            if (evs[i].sc == sc && evs[i].cyc == cyc && evs[i].ch == ch && evs[i].kind == kind)
                return 1;
        return 0;
    endfunction

    function automatic int get_a(input int kind, input int ch);
        case (kind)
            0:       return int'(a_press[ch]);
            1:       return int'(a_rel[ch]);
            2:       return int'(a_short[ch]);
            3:       return int'(a_long[ch]);
            default: return int'(a_rep[ch]);
        endcase
    endfunction

    function automatic int get_b(input int kind, input int ch);
        case (kind)
            0:       return int'(b_press[ch]);
            1:       return int'(b_rel[ch]);
            2:       return int'(b_short[ch]);
            3:       return int'(b_long[ch]);
            default: return int'(b_rep[ch]);
        endcase
    endfunction

    function automatic logic in_win(input int c, input int on, input int off);
        return (c >= on) && (c < off);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_a_outs"}, int'({a_level, a_press, a_rel, a_short, a_long, a_rep, a_any}), 0);
        check({tag, "_b_outs"}, int'({b_level, b_press, b_rel, b_short, b_long, b_rep, b_any}), 0);
    endtask

    initial begin
        // len, ch0 window A, ch0 window B, ch1 window, reset cycle (-1 = none)
        set_scen(0, 30,  0, 3,  5,  8, -1, -1, -1);  // bounce
        set_scen(1, 25,  0, 10, -1, -1, -1, -1, -1); // short press
        set_scen(2, 60,  0, 45, -1, -1, -1, -1, -1); // long + repeat
        set_scen(3, 70,  0, 70, -1, -1, -1, -1, 30); // reset mid-hold
        set_scen(4, 40,  0, 40, -1, -1,  0, 10, -1); // concurrency
        set_scen(5, 35,  0, 20, -1, -1, -1, -1, -1); // release coincides with long
        set_scen(6, 84,  0, 68, -1, -1, -1, -1, -1); // release coincides with repeat

        add_ev(1, 6, 0, 0);  add_ev(1, 16, 0, 1); add_ev(1, 16, 0, 2);

        add_ev(2, 6, 0, 0);  add_ev(2, 26, 0, 3); add_ev(2, 34, 0, 4);
        add_ev(2, 42, 0, 4);
        add_ev(2, 50, 0, 4); // debounced level still high on this edge
        add_ev(2, 51, 0, 1);

        add_ev(3, 6, 0, 0);  add_ev(3, 26, 0, 3); add_ev(3, 37, 0, 0);
        add_ev(3, 57, 0, 3); add_ev(3, 65, 0, 4);

        add_ev(4, 6, 0, 0);  add_ev(4, 26, 0, 3); add_ev(4, 34, 0, 4);
        add_ev(4, 6, 1, 0);  add_ev(4, 16, 1, 1); add_ev(4, 16, 1, 2);

        add_ev(5, 6, 0, 0);  add_ev(5, 26, 0, 1); add_ev(5, 26, 0, 2);

        add_ev(6, 6, 0, 0);  add_ev(6, 26, 0, 3);
        add_ev(6, 34, 0, 4); add_ev(6, 42, 0, 4); add_ev(6, 50, 0, 4);
        add_ev(6, 58, 0, 4); add_ev(6, 66, 0, 4); add_ev(6, 74, 0, 1);

        add_lvl(1, 8, 2'b01, 1'b1);  add_lvl(1, 20, 2'b00, 1'b0);
        add_lvl(3, 30, 2'b00, 1'b0); add_lvl(3, 31, 2'b00, 1'b0);
        add_lvl(3, 38, 2'b01, 1'b1);
        add_lvl(4, 8, 2'b11, 1'b1);  add_lvl(4, 20, 2'b01, 1'b1);

        reset = 1'b1;
        raw   = 2'b00;

        for (int s = 0; s < NSC; s++) begin
            reset = 1'b1;
            raw   = 2'b00;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check_all_zero($sformatf("sc%0d_reset", s));

            for (int c = 0; c < scen[s].len; c++) begin
                raw[0] = in_win(c, scen[s].r0a_on, scen[s].r0a_off) |
                         in_win(c, scen[s].r0b_on, scen[s].r0b_off);
                raw[1] = in_win(c, scen[s].r1_on, scen[s].r1_off);
                reset  = (c == scen[s].rst_cyc);
                @(posedge clk);
                #1;
                for (int ch = 0; ch < 2; ch++) begin
                    for (int k = 0; k < 5; k++) begin
                        check($sformatf("sc%0d_c%0d_ch%0d_k%0d_a", s, c, ch, k),
                              get_a(k, ch), expected(s, c, ch, k, 1'b0));
                        check($sformatf("sc%0d_c%0d_ch%0d_k%0d_b", s, c, ch, k),
                              get_b(k, ch), expected(s, c, ch, k, 1'b1));
                    end
                end
                if (s == 0) begin
                    check($sformatf("bounce_c%0d_level_a", c), int'({a_level, a_any}), 0);
                    check($sformatf("bounce_c%0d_level_b", c), int'({b_level, b_any}), 0);
                end
                foreach (lvls[i]) begin
                    if (lvls[i].sc == s && lvls[i].cyc == c) begin
                        check($sformatf("sc%0d_c%0d_level_a", s, c), int'(a_level),
                              int'(lvls[i].lvl));
                        check($sformatf("sc%0d_c%0d_any_a", s, c), int'(a_any),
                              int'(lvls[i].any));
                        check($sformatf("sc%0d_c%0d_level_b", s, c), int'(b_level),
                              int'(lvls[i].lvl));
                        check($sformatf("sc%0d_c%0d_any_b", s, c), int'(b_any),
                              int'(lvls[i].any));
                    end
                end
            end
        end

        reset = 1'b1;
        raw   = 2'b11;
        @(posedge clk);
        #1;
        check_all_zero("final_reset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
